// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio DAC buffer slice.
package audio_pkg;

  // Default sample width: left channel in [31:16], right channel in [15:0].
  localparam int unsigned AudioWidth    = 32;
  localparam int unsigned AudioDepth    = 16;
  localparam int unsigned AudioAemptyTh = 4;

  // Value played when the codec asks for a sample and none is buffered.
  localparam logic [AudioWidth-1:0] MuteSample = '0;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_dac_buffer_if.sv
// Producer-side sample stream into the audio DAC buffer (valid/ready handshake).
interface audio_dac_buffer_if #(
  parameter int unsigned WIDTH = audio_pkg::AudioWidth
);

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  // Producer side.
  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  // Buffer side.
  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/audio_sync_fifo.sv
// Single-clock sample FIFO: storage, wrapping pointers and an exact occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored; clr wins over both.
module audio_sync_fifo
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = AudioWidth,
  parameter int unsigned DEPTH = AudioDepth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] level_next,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = level_width(DEPTH);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LvlFull);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;

  // Next-state pointers and level; pointers wrap naturally since DEPTH is a power of 2,
  // and the separate level counter keeps full and empty distinct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        level_d = level_q + LvlW'(1);
      end else if (pop_ok && !push_ok) begin
        level_d = level_q - LvlW'(1);
      end
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents need no reset because level guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign level_next = level_d;

endmodule

// File: rtl/audio_dac_buffer.sv
// Audio DAC sample buffer: FIFO between a sample producer and a codec transceiver that
// pulls one sample per dac_req into a held output register.
// Build option: define AUDIO_DAC_BUF_REPEAT_EN to replay the last popped sample on
// underrun instead of outputting mute.
module audio_dac_buffer
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH     = AudioWidth,
  parameter int unsigned DEPTH     = AudioDepth,
  parameter int unsigned AEMPTY_TH = AudioAemptyTh
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  audio_dac_buffer_if.slave        s_if,
  input  logic                     dac_req,
  output logic [WIDTH-1:0]         dac_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_empty,
  output logic                     underrun
);

  localparam int unsigned LvlW = level_width(DEPTH);

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic [WIDTH-1:0] underrun_val;
  logic [LvlW-1:0]  fifo_level;
  logic [LvlW-1:0]  level_d;

  logic             ready_q, ready_d;
  logic [WIDTH-1:0] dac_data_q, dac_data_d;
  logic             underrun_q, underrun_d;
  logic             almost_empty_q, almost_empty_d;

  // ready_q is low in reset and rises on the first clock after release; flush gates it
  // combinationally so nothing is accepted in the flush cycle.
  assign s_if.s_ready = ready_q && !flush;
  assign push         = s_if.s_valid && s_if.s_ready;
  assign pop          = dac_req && !flush && !fifo_empty;

`ifdef AUDIO_DAC_BUF_REPEAT_EN
  // dac_data only changes on pop, underrun or flush, so it always holds the last sample played.
  assign underrun_val = dac_data_q;
`else
  assign underrun_val = WIDTH'(MuteSample);
`endif

  audio_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (flush),
    .push       (push),
    .wdata      (s_if.s_data),
    .pop        (pop),
    .rdata      (fifo_rdata),
    .level      (fifo_level),
    .level_next (level_d),
    .empty      (fifo_empty)
  );

  // Next-state output register, underrun pulse and level-derived flags.
  always_comb begin
    dac_data_d     = dac_data_q;
    underrun_d     = 1'b0;
    ready_d        = (level_d != LvlW'(DEPTH));
    almost_empty_d = (level_d <= LvlW'(AEMPTY_TH));
    if (flush) begin
      dac_data_d = '0;
    end else if (dac_req) begin
      if (fifo_empty) begin
        // A same-cycle push does not bypass: the request still sees an empty buffer.
        underrun_d = 1'b1;
        dac_data_d = underrun_val;
      end else begin
        dac_data_d = fifo_rdata;
      end
    end
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q        <= 1'b0;
      dac_data_q     <= '0;
      underrun_q     <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      ready_q        <= ready_d;
      dac_data_q     <= dac_data_d;
      underrun_q     <= underrun_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign dac_data     = dac_data_q;
  assign level        = fifo_level;
  assign almost_empty = almost_empty_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_dac_buffer.sv
// Directed self-checking bench for audio_dac_buffer (WIDTH=32, DEPTH=16, AEMPTY_TH=4).
module tb_audio_dac_buffer;

`ifdef AUDIO_DAC_BUF_REPEAT_EN
  localparam logic [31:0] UndVal = 32'hAAAA5555;
`else
  localparam logic [31:0] UndVal = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dac_req;
  logic [31:0] dac_data;
  logic [4:0]  level;
  logic        almost_empty;
  logic        underrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] exp_word;
  logic [31:0] din;
  int          exp_level;
  logic        ae_prev;
  int          toggles;

  audio_dac_buffer_if #(.WIDTH(32)) s_if ();

  audio_dac_buffer #(
    .WIDTH     (32),
    .DEPTH     (16),
    .AEMPTY_TH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .s_if         (s_if),
    .dac_req      (dac_req),
    .dac_data     (dac_data),
    .level        (level),
    .almost_empty (almost_empty),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    dac_req      = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    // Reset values while rst_n is low.
    #12;
    check("rst_ready", 32'(s_if.s_ready), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_dac_data", dac_data, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(s_if.s_ready), 32'd1);

    // Two pushes then a request.
    s_if.s_valid = 1'b1;
    s_if.s_data  = 32'h11112222;
    tick();
    s_if.s_data  = 32'h33334444;
    tick();
    s_if.s_valid = 1'b0;
    check("two_push_level", 32'(level), 32'd2);
    check("two_push_aempty", 32'(almost_empty), 32'd1);
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    check("pop1_data", dac_data, 32'h11112222);
    check("pop1_level", 32'(level), 32'd1);
    check("pop1_underrun", 32'(underrun), 32'd0);
    tick();
    check("hold_data", dac_data, 32'h11112222);
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    check("pop2_data", dac_data, 32'h33334444);
    check("pop2_level", 32'(level), 32'd0);

    // Underrun after last sample 0xAAAA5555.
    s_if.s_valid = 1'b1;
    s_if.s_data  = 32'hAAAA5555;
    tick();
    s_if.s_valid = 1'b0;
    dac_req = 1'b1;
    tick();
    check("pop_aaaa_data", dac_data, 32'hAAAA5555);
    tick();
    dac_req = 1'b0;
    check("und_pulse", 32'(underrun), 32'd1);
    check("und_data", dac_data, UndVal);
    check("und_level", 32'(level), 32'd0);
    tick();
    check("und_one_cycle", 32'(underrun), 32'd0);
    check("und_hold_data", dac_data, UndVal);

    // Push and request together on an empty buffer: underrun, sample kept.
    s_if.s_valid = 1'b1;
    s_if.s_data  = 32'h0BAD0001;
    dac_req      = 1'b1;
    tick();
    s_if.s_valid = 1'b0;
    check("nobypass_und", 32'(underrun), 32'd1);
    check("nobypass_level", 32'(level), 32'd1);
    check("nobypass_data", dac_data, UndVal);
    tick();
    dac_req = 1'b0;
    check("nobypass_pop_data", dac_data, 32'h0BAD0001);
    check("nobypass_pop_und", 32'(underrun), 32'd0);
    check("nobypass_pop_level", 32'(level), 32'd0);

    // Fill to DEPTH, then pop while the producer keeps pushing.
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_if.s_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    check("full_level", 32'(level), 32'd16);
    check("full_ready", 32'(s_if.s_ready), 32'd0);
    check("full_aempty", 32'(almost_empty), 32'd0);
    s_if.s_data = 32'h1000_0010;
    dac_req     = 1'b1;
    tick();
    dac_req = 1'b0;
    check("full_pop_level", 32'(level), 32'd15);
    check("full_pop_data", dac_data, 32'h1000_0000);
    check("full_pop_ready", 32'(s_if.s_ready), 32'd1);
    tick();
    s_if.s_valid = 1'b0;
    check("refill_level", 32'(level), 32'd16);
    check("refill_ready", 32'(s_if.s_ready), 32'd0);
    dac_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("drain_data", dac_data, 32'h1000_0000 + 32'(k));
      check("drain_level", 32'(level), 32'(16 - k));
    end
    dac_req = 1'b0;

    // Flush with a simultaneous request and push.
    s_if.s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_if.s_data = 32'h2000_0000 + 32'(i);
      tick();
    end
    check("preflush_level", 32'(level), 32'd3);
    flush        = 1'b1;
    dac_req      = 1'b1;
    s_if.s_data  = 32'h2000_00FF;
    #1;
    check("flush_ready", 32'(s_if.s_ready), 32'd0);
    tick();
    flush        = 1'b0;
    dac_req      = 1'b0;
    s_if.s_valid = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_data", dac_data, 32'd0);
    check("flush_und", 32'(underrun), 32'd0);
    check("flush_aempty", 32'(almost_empty), 32'd1);
    tick();
    check("postflush_und", 32'(underrun), 32'd0);
    check("postflush_level", 32'(level), 32'd0);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 32'h5A5A0001;
    tick();
    s_if.s_valid = 1'b0;
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    check("postflush_pop", dac_data, 32'h5A5A0001);

    // 40 cycles of streaming across the pointer wrap.
    exp_level = 0;
    ae_prev   = 1'b1;
    toggles   = 0;
    for (int c = 0; c < 40; c++) begin
      din          = 32'hC0DE_0000 + 32'(c);
      s_if.s_valid = (c < 34);
      s_if.s_data  = din;
      dac_req      = (c >= 6);
      tick();
      if (c >= 6) begin
        exp_word = exp_q.pop_front();
        check("stream_data", dac_data, exp_word);
        exp_level--;
      end
      if (c < 34) begin
        exp_q.push_back(din);
        exp_level++;
      end
      check("stream_level", 32'(level), 32'(exp_level));
      check("stream_aempty", 32'(almost_empty), 32'(exp_level <= 4));
      if (almost_empty !== ae_prev) toggles++;
      ae_prev = almost_empty;
    end
    s_if.s_valid = 1'b0;
    dac_req      = 1'b0;
    check("stream_aempty_toggles", 32'(toggles), 32'd2);

    // Asynchronous reset mid-stream with level 7.
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.s_data = 32'h3000_0000 + 32'(i);
      tick();
    end
    s_if.s_valid = 1'b0;
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    check("midrst_pre_level", 32'(level), 32'd7);
    check("midrst_pre_data", dac_data, 32'h3000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_data", dac_data, 32'd0);
    check("midrst_aempty", 32'(almost_empty), 32'd1);
    check("midrst_und", 32'(underrun), 32'd0);
    check("midrst_ready", 32'(s_if.s_ready), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check("midrst_ready_after", 32'(s_if.s_ready), 32'd1);
    check("midrst_level_after", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
